writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Initiator side of the register-file write port. Merges results from the single-cycle ALU path and the multi-cycle load path into one registered write stream (reg_write_enable / reg_write_addr / reg_write_data).
- Load results are buffered in a small FIFO, and the ALU path has priority, subject to a bounded starvation limit.
- Keeps a 32-bit pending-write scoreboard. Operand fetch uses it to detect RAW hazards on registers whose results have not yet been written.

Parameters:
- DATA_WIDTH, 32, width of written data.
- ADDR_WIDTH, 5, register address width (32 registers).
- LQ_DEPTH, 4, load-queue entries; must be a power of 2 and at least 2.
- STARVE_LIMIT, 3, consecutive cycles a non-empty load-queue head may be bypassed by the ALU before it is forced out.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (reset=0 resets the block).
- alu_valid  in  1  ALU result present this cycle.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_addr  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load queue can accept.
- ld_addr  in  ADDR_WIDTH  load destination register.
- ld_data  in  DATA_WIDTH  load data.
- claim_valid  in  1  issue stage marks a destination as pending.
- claim_addr  in  ADDR_WIDTH  register being claimed.
- busy_mask  out  32  bit r=1 means a write to register r is outstanding.
- lq_count  out  clog2(LQ_DEPTH)+1  current queue occupancy.
- reg_write_enable  out  1  write strobe to the register file.
- reg_write_addr  out  ADDR_WIDTH  write address.
- reg_write_data  out  DATA_WIDTH  write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - Queue is emptied and queued loads are discarded.
  - lq_count=0, busy_mask=0, starve counter=0.
  - reg_write_enable=0, reg_write_addr=0, reg_write_data=0.
  - ld_ready=1 and alu_ready=1 once reset is released.
- Load enqueue:
  - Occurs on ld_valid & ld_ready.
  - ld_ready = (lq_count != LQ_DEPTH), combinational from registered state. There is no bypass of a full queue.
  - An enqueue and a dequeue in the same cycle are both legal; occupancy is unchanged.
- Per-cycle selection:
  - force = (lq_count != 0) & (starve_cnt == STARVE_LIMIT).
  - alu_ready = !force.
  - If alu_valid & alu_ready, the ALU result is selected.
  - Else if lq_count != 0, the queue head is selected and popped.
  - Else nothing is selected.
- Starve counter:
  - Increments when the queue is non-empty and the ALU wins.
  - Clears on any queue pop, and whenever the queue is empty.
  - Saturates at STARVE_LIMIT.
- Output:
  - One-cycle latency: the selected entry appears on reg_write_addr/data at the next rising edge.
  - reg_write_enable pulses high for exactly one cycle per accepted write.
  - When nothing is selected, reg_write_enable=0 and reg_write_addr/data hold their previous values.
  - Address 0: the entry is consumed (handshake completes, queue pops) but reg_write_enable stays 0.
- Ordering: the load queue is strict FIFO. ALU-vs-load ordering to the same register is the issue stage's responsibility and is not checked here.
- Scoreboard:
  - claim_valid with claim_addr!=0 sets busy_mask[claim_addr] at the next edge.
  - The edge that loads a selected write into the output register clears busy_mask[addr].
  - Simultaneous claim and clear of the same address: the claim wins and the bit stays 1.
  - busy_mask[0] is always 0.
- lq_count is always the true occupancy, in the range 0..LQ_DEPTH.

Test Plan:
- Reset sequence: hold reset=0 mid-stream with 2 loads queued -> outputs 0, lq_count=0, busy_mask=0; after release, ld_ready=1 and no stale writes appear.
- ALU only: alu_valid, addr=5, data=0xDEADBEEF -> next cycle reg_write_enable=1, addr=5, data=0xDEADBEEF for exactly 1 cycle; a prior claim of r5 clears busy_mask[5].
- Queue full: enqueue 4 loads while the ALU is continuously valid -> ld_ready=0 at lq_count=4. With STARVE_LIMIT=3: alu_ready drops once, the head is written, lq_count returns to 3, and ld_ready returns to 1.
- FIFO drain: loads to r1,r2,r3 with the ALU idle -> writes on 3 consecutive cycles in order r1,r2,r3.
- Address 0: ALU write to r0 -> alu_ready=1, reg_write_enable remains 0; a claim of r0 leaves busy_mask=0.
- Claim/clear race: r7 written by the ALU in the same cycle as a new claim of r7 -> busy_mask[7]=1 after the edge.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: the ALU path has priority over a small load FIFO,
// with a bounded starvation limit for the FIFO head, plus a pending-write scoreboard.
module writeback_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [ADDR_WIDTH-1:0]       alu_addr,
  input  logic [DATA_WIDTH-1:0]       alu_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [ADDR_WIDTH-1:0]       ld_addr,
  input  logic [DATA_WIDTH-1:0]       ld_data,
  input  logic                        claim_valid,
  input  logic [ADDR_WIDTH-1:0]       claim_addr,
  output logic [31:0]                 busy_mask,
  output logic [$clog2(LQ_DEPTH):0]   lq_count,
  output logic                        reg_write_enable,
  output logic [ADDR_WIDTH-1:0]       reg_write_addr,
  output logic [DATA_WIDTH-1:0]       reg_write_data
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // ready never depends on valid, so a source may hold valid and wait.
  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [ADDR_WIDTH-1:0] lq_addr_q [LQ_DEPTH];
  logic [ADDR_WIDTH-1:0] lq_addr_d [LQ_DEPTH];
  logic [DATA_WIDTH-1:0] lq_data_q [LQ_DEPTH];
  logic [DATA_WIDTH-1:0] lq_data_d [LQ_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [SC_W-1:0]       starve_q, starve_d;
  logic [31:0]           busy_q, busy_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  lq_empty, lq_full, force_head;
  logic                  sel_alu, pop, push, selected;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    lq_empty   = (count_q == '0);
    lq_full    = (count_q == CNT_W'(LQ_DEPTH));
    force_head = !lq_empty && (starve_q == SC_W'(STARVE_LIMIT));
    alu_ready  = !force_head;
    ld_ready   = !lq_full;
    sel_alu    = alu_valid && !force_head;
    pop        = !sel_alu && !lq_empty;
    push       = ld_valid && !lq_full;
    selected   = sel_alu || pop;
    sel_addr   = sel_alu ? alu_addr : lq_addr_q[rd_ptr_q];
    sel_data   = sel_alu ? alu_data : lq_data_q[rd_ptr_q];

    lq_addr_d = lq_addr_q;
    lq_data_d = lq_data_q;
    if (push) begin
      lq_addr_d[wr_ptr_q] = ld_addr;
      lq_data_d[wr_ptr_q] = ld_data;
    end
    // Pointers wrap naturally because the depth is a power of two.
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    // With a non-empty queue and no pop, the ALU must have won this cycle.
    starve_d = starve_q;
    if (lq_empty || pop)
      starve_d = '0;
    else if (starve_q != SC_W'(STARVE_LIMIT))
      starve_d = starve_q + SC_W'(1);

    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (selected) begin
      wen_d   = (sel_addr != '0);
      waddr_d = sel_addr;
      wdata_d = sel_data;
    end

    // Clear first so that a same-cycle claim of the same register wins.
    busy_d = busy_q;
    if (selected)
      busy_d[sel_addr] = 1'b0;
    if (claim_valid)
      busy_d[claim_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_addr_q[i] <= '0;
        lq_data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      busy_q   <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      lq_addr_q <= lq_addr_d;
      lq_data_q <= lq_data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      busy_q    <= busy_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign busy_mask        = busy_q;
  assign lq_count         = count_q;
  assign reg_write_enable = wen_q;
  assign reg_write_addr   = waddr_q;
  assign reg_write_data   = wdata_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0, ld_valid = 1'b0, claim_valid = 1'b0;
  logic        alu_ready, ld_ready;
  logic [4:0]  alu_addr = '0, ld_addr = '0, claim_addr = '0;
  logic [31:0] alu_data = '0, ld_data = '0;
  logic [31:0] busy_mask;
  logic [2:0]  lq_count;
  logic        reg_write_enable;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;

  writeback_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .claim_valid(claim_valid), .claim_addr(claim_addr), .busy_mask(busy_mask),
    .lq_count(lq_count), .reg_write_enable(reg_write_enable),
    .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data)
  );

  always #5 clk = ~clk;

  // Reference model: the load queue is an ordered list of {addr,data}; bypass counts
  // how many times in a row the ALU has jumped ahead of a waiting load.
  logic [36:0] exp_q[$];
  int          m_bypass;
  logic [31:0] m_busy;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_hold_ok;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic bit m_alu_ready();
    return !(exp_q.size() != 0 && m_bypass >= 3);
  endfunction

  function automatic bit m_ld_ready();
    return exp_q.size() < 4;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_bypass = 0; m_busy = '0; m_wen = 1'b0;
    m_waddr = '0; m_wdata = '0; m_hold_ok = 1'b1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; ld_valid = 1'b0; claim_valid = 1'b0;
  endtask

  // Advance the model by one cycle using the currently driven inputs, then clock the DUT.
  task automatic step();
    bit          has_load = exp_q.size() != 0;
    bit          take_alu = alu_valid && m_alu_ready();
    bit          take_ld  = !take_alu && has_load;
    bit          accept   = ld_valid && m_ld_ready();
    logic [4:0]  a = '0;
    logic [31:0] d = '0;
    if (take_alu) begin a = alu_addr; d = alu_data; end
    else if (take_ld) {a, d} = exp_q.pop_front();
    if (!has_load || take_ld) m_bypass = 0;
    else if (m_bypass < 3) m_bypass++;
    if (accept) exp_q.push_back({ld_addr, ld_data});
    m_wen = (take_alu || take_ld) && a != 0;
    if (take_alu || take_ld) begin
      if (a != 0) begin m_waddr = a; m_wdata = d; m_hold_ok = 1'b1; end
      else m_hold_ok = 1'b0;
      m_busy[a] = 1'b0;
    end
    if (claim_valid) m_busy[claim_addr] = 1'b1;
    m_busy[0] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (reg_write_enable !== 1'b0) $display("FAIL reset_wen got=%0b exp=0", reg_write_enable); else n_pass++;
    n_checks++; if (reg_write_addr !== 5'd0 || reg_write_data !== 32'd0) $display("FAIL reset_wdata got=%0d/%h exp=0/0", reg_write_addr, reg_write_data); else n_pass++;
    n_checks++; if (lq_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", lq_count); else n_pass++;
    n_checks++; if (busy_mask !== 32'd0) $display("FAIL reset_busy got=%h exp=0", busy_mask); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    n_checks++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) $display("FAIL reset_ready got=%0b%0b exp=11", ld_ready, alu_ready); else n_pass++;
    // Queue two loads behind a busy ALU, then reset in mid-cycle.
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1'b1; alu_addr = 5'd9; alu_data = $urandom;
      ld_valid = 1'b1; ld_addr = 5'(10 + i); ld_data = $urandom;
      claim_valid = 1'b1; claim_addr = 5'(12 + i);
      step();
    end
    idle();
    n_checks++; if (lq_count !== 3'd2) $display("FAIL reset_prefill got=%0d exp=2", lq_count); else n_pass++;
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_checks++; if (lq_count !== 3'd0 || busy_mask !== 32'd0) $display("FAIL reset_async got=%0d/%h exp=0/0", lq_count, busy_mask); else n_pass++;
    n_checks++; if (reg_write_enable !== 1'b0 || reg_write_addr !== 5'd0 || reg_write_data !== 32'd0) $display("FAIL reset_async_out got=%0b/%0d/%h exp=0/0/0", reg_write_enable, reg_write_addr, reg_write_data); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    n_checks++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) $display("FAIL reset_release got=%0b%0b exp=11", ld_ready, alu_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (reg_write_enable !== 1'b0 || lq_count !== 3'd0) $display("FAIL reset_stale cyc=%0d got=%0b/%0d exp=0/0", i, reg_write_enable, lq_count); else n_pass++;
    end
  endtask

  task automatic test_alu_only();
    claim_valid = 1'b1; claim_addr = 5'd5;
    step();
    idle();
    n_checks++; if (busy_mask !== 32'h20) $display("FAIL alu_claim got=%h exp=00000020", busy_mask); else n_pass++;
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    n_checks++; if (alu_ready !== 1'b1) $display("FAIL alu_ready got=%0b exp=1", alu_ready); else n_pass++;
    step();
    idle();
    n_checks++; if (reg_write_enable !== 1'b1 || reg_write_addr !== 5'd5 || reg_write_data !== 32'hDEADBEEF) $display("FAIL alu_write got=%0b/%0d/%h exp=1/5/deadbeef", reg_write_enable, reg_write_addr, reg_write_data); else n_pass++;
    n_checks++; if (busy_mask !== 32'd0) $display("FAIL alu_clear got=%h exp=0", busy_mask); else n_pass++;
    step();
    n_checks++; if (reg_write_enable !== 1'b0 || reg_write_addr !== 5'd5 || reg_write_data !== 32'hDEADBEEF) $display("FAIL alu_hold got=%0b/%0d/%h exp=0/5/deadbeef", reg_write_enable, reg_write_addr, reg_write_data); else n_pass++;
  endtask

  task automatic test_queue_full();
    logic [4:0] first_addr = 5'd0;
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'b1; alu_addr = 5'($urandom_range(1, 31)); alu_data = $urandom;
      ld_valid = 1'b1; ld_addr = 5'($urandom_range(1, 31)); ld_data = $urandom;
      if (i == 0) first_addr = ld_addr;
      if (i < 4) begin
        n_checks++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1) $display("FAIL full_fill cyc=%0d got=%0b%0b exp=11", i, alu_ready, ld_ready); else n_pass++;
      end else begin
        n_checks++; if (lq_count !== 3'd4 || ld_ready !== 1'b0) $display("FAIL full_stall got=%0d/%0b exp=4/0", lq_count, ld_ready); else n_pass++;
        n_checks++; if (alu_ready !== 1'b0) $display("FAIL full_force got=%0b exp=0", alu_ready); else n_pass++;
      end
      step();
    end
    idle();
    n_checks++; if (lq_count !== 3'd3 || ld_ready !== 1'b1) $display("FAIL full_after got=%0d/%0b exp=3/1", lq_count, ld_ready); else n_pass++;
    n_checks++; if (reg_write_enable !== 1'b1 || reg_write_addr !== first_addr) $display("FAIL full_head got=%0b/%0d exp=1/%0d", reg_write_enable, reg_write_addr, first_addr); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (reg_write_enable !== m_wen || reg_write_addr !== m_waddr || reg_write_data !== m_wdata) $display("FAIL full_drain cyc=%0d got=%0b/%0d/%h exp=%0b/%0d/%h", i, reg_write_enable, reg_write_addr, reg_write_data, m_wen, m_waddr, m_wdata); else n_pass++;
    end
  endtask

  task automatic test_fifo_drain();
    logic        exp_wen [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0]  exp_addr[5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd3};
    logic [31:0] dat[3];
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 3) begin
        dat[i] = $urandom;
        ld_valid = 1'b1; ld_addr = 5'(i + 1); ld_data = dat[i];
      end
      step();
      n_checks++; if (reg_write_enable !== exp_wen[i]) $display("FAIL drain_wen cyc=%0d got=%0b exp=%0b", i, reg_write_enable, exp_wen[i]); else n_pass++;
      if (i >= 1) begin
        n_checks++; if (reg_write_addr !== exp_addr[i] || reg_write_data !== dat[(i < 4) ? i - 1 : 2]) $display("FAIL drain_order cyc=%0d got=%0d/%h exp=%0d/%h", i, reg_write_addr, reg_write_data, exp_addr[i], dat[(i < 4) ? i - 1 : 2]); else n_pass++;
      end
    end
    idle();
  endtask

  task automatic test_addr0();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = $urandom;
    claim_valid = 1'b1; claim_addr = 5'd0;
    n_checks++; if (alu_ready !== 1'b1) $display("FAIL a0_ready got=%0b exp=1", alu_ready); else n_pass++;
    step();
    idle();
    n_checks++; if (reg_write_enable !== 1'b0 || busy_mask !== 32'd0) $display("FAIL a0_alu got=%0b/%h exp=0/0", reg_write_enable, busy_mask); else n_pass++;
    ld_valid = 1'b1; ld_addr = 5'd0; ld_data = $urandom;
    step();
    idle();
    step();
    n_checks++; if (reg_write_enable !== 1'b0 || lq_count !== 3'd0) $display("FAIL a0_load got=%0b/%0d exp=0/0", reg_write_enable, lq_count); else n_pass++;
  endtask

  task automatic test_claim_race();
    claim_valid = 1'b1; claim_addr = 5'd7;
    step();
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h0000_7777;
    step();
    idle();
    n_checks++; if (reg_write_enable !== 1'b1 || reg_write_addr !== 5'd7) $display("FAIL race_write got=%0b/%0d exp=1/7", reg_write_enable, reg_write_addr); else n_pass++;
    n_checks++; if (busy_mask[7] !== 1'b1) $display("FAIL race_busy got=%h exp=bit7 set", busy_mask); else n_pass++;
    step();
    alu_valid = 1'b1;
    step();
    idle();
    n_checks++; if (busy_mask !== 32'd0) $display("FAIL race_clear got=%h exp=0", busy_mask); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      alu_valid   = ($urandom_range(0, 99) < 55);
      alu_addr    = 5'($urandom_range(0, 31));
      alu_data    = $urandom;
      ld_valid    = ($urandom_range(0, 99) < 60);
      ld_addr     = 5'($urandom_range(0, 31));
      ld_data     = $urandom;
      claim_valid = ($urandom_range(0, 99) < 30);
      claim_addr  = 5'($urandom_range(0, 31));
      n_checks++; if (alu_ready !== m_alu_ready() || ld_ready !== m_ld_ready()) $display("FAIL rnd_ready cyc=%0d got=%0b%0b exp=%0b%0b", i, alu_ready, ld_ready, m_alu_ready(), m_ld_ready()); else n_pass++;
      step();
      n_checks++; if (reg_write_enable !== m_wen || lq_count !== 3'(exp_q.size())) $display("FAIL rnd_wen cyc=%0d got=%0b/%0d exp=%0b/%0d", i, reg_write_enable, lq_count, m_wen, exp_q.size()); else n_pass++;
      n_checks++; if (busy_mask !== m_busy) $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", i, busy_mask, m_busy); else n_pass++;
      if (m_hold_ok) begin
        n_checks++; if (reg_write_addr !== m_waddr || reg_write_data !== m_wdata) $display("FAIL rnd_data cyc=%0d got=%0d/%h exp=%0d/%h", i, reg_write_addr, reg_write_data, m_waddr, m_wdata); else n_pass++;
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu_only();
    test_queue_full();
    test_fifo_drain();
    test_addr0();
    test_claim_race();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
